// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants, the encoder's op-kind enum and its FSM state type.
// The control decoder imports the same opcode/funct values.
package mips_isa_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_JR,
        OP_ADDI, OP_SLTI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
        OP_J, OP_JAL
    } op_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int FIFO_DEPTH = 2;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor-to-instruction packer; fields a format does not use are zeroed.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = pack_r(rs, rt, rd, 5'd0, FN_ADD);
            OP_ADDU: word = pack_r(rs, rt, rd, 5'd0, FN_ADDU);
            OP_SUB:  word = pack_r(rs, rt, rd, 5'd0, FN_SUB);
            OP_SUBU: word = pack_r(rs, rt, rd, 5'd0, FN_SUBU);
            OP_AND:  word = pack_r(rs, rt, rd, 5'd0, FN_AND);
            OP_OR:   word = pack_r(rs, rt, rd, 5'd0, FN_OR);
            OP_SLT:  word = pack_r(rs, rt, rd, 5'd0, FN_SLT);
            OP_SLL:  word = pack_r(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:  word = pack_r(5'd0, rt, rd, shamt, FN_SRL);
            OP_SRA:  word = pack_r(5'd0, rt, rd, shamt, FN_SRA);
            OP_JR:   word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_ADDI: word = pack_i(OPC_ADDI, rs, rt, imm);
            OP_SLTI: word = pack_i(OPC_SLTI, rs, rt, imm);
            OP_ORI:  word = pack_i(OPC_ORI, rs, rt, imm);
            OP_LUI:  word = pack_i(OPC_LUI, 5'd0, rt, imm);
            OP_LW:   word = pack_i(OPC_LW, rs, rt, imm);
            OP_SW:   word = pack_i(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = pack_i(OPC_BEQ, rs, rt, imm);
            OP_BNE:  word = pack_i(OPC_BNE, rs, rt, imm);
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: accepts descriptors, packs them and queues {word, addr}
// pairs in a 2-entry FIFO toward the instruction-memory write port.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic              in_last,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              illegal,
    output logic [15:0]       word_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              illegal_q, illegal_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [31:0]       word_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        accept;
    logic        push;
    logic        pop;

    instr_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    // No bypass: a full FIFO blocks input even if the head pops this cycle.
    assign in_ready  = (state_q == ST_RUN) && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && pack_legal;
    assign pop       = out_valid && out_ready;

    assign out_word  = word_mem_q[rd_ptr_q];
    assign out_addr  = addr_mem_q[rd_ptr_q];
    assign done      = (state_q == ST_DRAIN) && (count_q == 2'd0);
    assign illegal   = illegal_q;
    assign word_cnt  = word_cnt_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        illegal_d  = illegal_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            addr_d   = addr_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    addr_d     = BASE_ADDR;
                    word_cnt_d = 16'd0;
                    illegal_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && !pack_legal) begin
                    illegal_d = 1'b1;
                end
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            word_cnt_q <= 16'd0;
            illegal_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            illegal_q  <= illegal_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entries reset to {0, BASE_ADDR} so the idle head shows the reset output values.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_mem_q[gi] <= 32'h0000_0000;
                addr_mem_q[gi] <= BASE_ADDR;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                word_mem_q[gi] <= pack_word;
                addr_mem_q[gi] <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: expected {word, addr} pairs are queued
// on descriptor acceptance and compared as words pop from the output port.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic        in_last;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        done;
    logic        illegal;
    logic [15:0] word_cnt;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [31:0] exp_addr = 32'h0000_3000;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_last   (in_last),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .done      (done),
        .illegal   (illegal),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample the handshake mid-cycle, then advance to 1 time unit past the next edge.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", out_word, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                check("out_word", out_word, e.w);
                check("out_addr", out_addr, e.a);
            end
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = 32'h0000_3000;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last, input bit legal,
                         input logic [31:0] w);
        logic acc;
        int   n;
        exp_t e;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            acc = in_ready;
            if (acc && legal) begin
                e.w = w;
                e.a = exp_addr;
                sb.push_back(e);
                exp_addr = exp_addr + 32'd4;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_done();
        int snap;
        int n;
        snap = done_cnt;
        n = 0;
        while (done_cnt == snap && n < 40) begin
            step();
            n++;
        end
        repeat (3) step();
        check("done_once", done_cnt - snap, 32'd1);
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = 5'd0; in_last = 1'b0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 16'd0;
        in_target = 26'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_addr", out_addr, 32'h3000);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // ADDU with shamt masked
        pulse_start();
        check("run_in_ready", {31'd0, in_ready}, 32'd1);
        drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0022_1821);
        wait_done();
        check("cnt_addu", {16'd0, word_cnt}, 32'd1);

        // ORI / LUI (rs masked) / JAL stream
        pulse_start();
        check("cnt_after_start", {16'd0, word_cnt}, 32'd0);
        drive(5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0, 1'b1, 32'h3408_00FF);
        drive(5'd14, 5'd5, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h3C09_1234);
        drive(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00, 1'b1, 1'b1, 32'h0C00_0C00);
        wait_done();
        check("cnt_stream", {16'd0, word_cnt}, 32'd3);

        // Backpressure: FIFO fills after 2, head held stable
        pulse_start();
        out_ready = 1'b0;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
        drive(5'd5, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0085_3025);
        in_op = 5'd7; in_rs = 5'd9; in_rt = 5'd7; in_rd = 5'd8; in_shamt = 5'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_word", out_word, 32'h0022_1820);
            check("hold_addr", out_addr, 32'h3000);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        drive(5'd7, 5'd9, 5'd7, 5'd8, 5'd4, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0007_4100);
        wait_done();
        check("cnt_hold", {16'd0, word_cnt}, 32'd3);

        // Illegal op then SW
        pulse_start();
        drive(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 1'b0, 1'b0, 32'h0);
        check("illegal_set", {31'd0, illegal}, 32'd1);
        check("illegal_no_word", {31'd0, out_valid}, 32'd0);
        drive(5'd16, 5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b1, 1'b1, 32'hAFBF_FFFC);
        wait_done();
        check("illegal_sticky", {31'd0, illegal}, 32'd1);
        check("cnt_illegal", {16'd0, word_cnt}, 32'd1);

        // Start clears illegal; reset with 2 words queued
        pulse_start();
        check("illegal_cleared", {31'd0, illegal}, 32'd0);
        out_ready = 1'b0;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
        drive(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1822);
        check("queued_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst2_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst2_out_word", out_word, 32'h0);
        check("rst2_out_addr", out_addr, 32'h3000);
        check("rst2_word_cnt", {16'd0, word_cnt}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // BEQ, ignored mid-run start, JR (rt masked)
        pulse_start();
        drive(5'd17, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0, 1'b1, 32'h1085_FFFE);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(5'd10, 5'd31, 5'd3, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 1'b1, 32'h03E0_0008);
        wait_done();
        check("cnt_final", {16'd0, word_cnt}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
